reorder_buffer: RTL and testbench

//  2-way in-order retirement queue of the R10K core; the producer side of the freelist's retire interface.

---
 rtl/sys_defs.sv | 24 ++
 rtl/rob_retire_sel.sv | 52 +++++
 rtl/reorder_buffer.sv | 136 +++++++++++++
 tb/tb_reorder_buffer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// -----------------------------------------------------------------------------
// sys_defs
//   Shared core definitions: ROB geometry, physical-tag width, and the ROB
//   entry record. Imported by the reorder buffer and its retire selector.
//   No ports.
// -----------------------------------------------------------------------------
package sys_defs;

  localparam int ROB_SIZE = 32;                 // entries, power of two
  localparam int ROB_PTR  = $clog2(ROB_SIZE);   // ROB index width
  localparam int N_WAY    = 2;                  // dispatch/retire/CDB width
  localparam int PHYS_REG = 6;                  // physical tag width (64 regs)
  localparam int FL_PTR   = 5;                  // freelist pointer width
  localparam int ARCH_W   = 5;                  // architectural register index
  localparam int CNT_W    = ROB_PTR + 1;        // occupancy 0..ROB_SIZE

  typedef struct packed {
    logic [PHYS_REG-1:0] tag;
    logic [PHYS_REG-1:0] tagOld;
    logic [ARCH_W-1:0]   destArch;
    logic                complete;
  } ROB_ENTRY;

endpackage

// File: rtl/rob_retire_sel.sv
// -----------------------------------------------------------------------------
// rob_retire_sel
//   Combinational retire selection. Looks at the head entry and the one after
//   it and decides how many retire this cycle (0..2, in order), and drives the
//   retire slots; slots that do not retire are driven to zero.
// Ports
//   head_entry_i   entry at head
//   next_entry_i   entry at head+1
//   count_i        current occupancy
//   n_retired_o    number retiring (0..2)
//   tag_o          committed tags, slot 0 older
//   tag_old_o      tags returned to the freelist, slot 0 older
//   arch_o         architectural destinations committed
// -----------------------------------------------------------------------------
module rob_retire_sel
  import sys_defs::*;
(
  input  ROB_ENTRY                        head_entry_i,
  input  ROB_ENTRY                        next_entry_i,
  input  logic [CNT_W-1:0]                count_i,
  output logic [1:0]                      n_retired_o,
  output logic [N_WAY-1:0][PHYS_REG-1:0]  tag_o,
  output logic [N_WAY-1:0][PHYS_REG-1:0]  tag_old_o,
  output logic [N_WAY-1:0][ARCH_W-1:0]    arch_o
);

  always_comb begin
    n_retired_o = 2'd0;
    tag_o       = '0;
    tag_old_o   = '0;
    arch_o      = '0;

    // Retirement is strictly in order: the second slot only retires when the
    // head retires too and a second valid, completed entry follows it.
    if (count_i != '0 && head_entry_i.complete) begin
      if (count_i == CNT_W'(1) || !next_entry_i.complete) n_retired_o = 2'd1;
      else                                                 n_retired_o = 2'd2;
    end

    if (n_retired_o != 2'd0) begin
      tag_o[0]     = head_entry_i.tag;
      tag_old_o[0] = head_entry_i.tagOld;
      arch_o[0]    = head_entry_i.destArch;
    end
    if (n_retired_o == 2'd2) begin
      tag_o[1]     = next_entry_i.tag;
      tag_old_o[1] = next_entry_i.tagOld;
      arch_o[1]    = next_entry_i.destArch;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//   2-way in-order retirement queue. Dispatch allocates up to two entries per
//   cycle at the tail; CDB lanes mark entries complete; up to two completed
//   entries retire per cycle from the head, returning tagOld to the freelist.
//   A branch mispredict rolls the tail back to the branch-stack snapshot.
//   Optional build macro ROB_DEBUG_EN adds rob_head, rob_count and
//   rob_completeVec outputs plus a per-cycle print of retired tags.
// Ports
//   clk, reset_n          clock (posedge), asynchronous active-low reset
//   haz_nDispatched       instructions dispatched this cycle (0..2)
//   fl_freeRegs           new tags per slot, slot 0 older
//   map_tagOld            previous mapping per slot
//   id_destArch           architectural destination per slot
//   cdb_valid/cdb_robIdx  completion broadcast per lane
//   br_fub_pred_wrong     mispredict: squash younger than the branch
//   bs_recov_rob_tail     snapshot tail (entry after the branch)
//   rob_tail              next allocation index
//   rob_availableSlots    free entries (ROB_SIZE - count)
//   rob_nRetired          entries retiring this cycle
//   rob_retireTagOld/rob_retireTag/rob_retireArch   retire slots, slot 0 older
// -----------------------------------------------------------------------------
module reorder_buffer
  import sys_defs::*;
(
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [1:0]                      haz_nDispatched,
  input  logic [N_WAY-1:0][PHYS_REG-1:0]  fl_freeRegs,
  input  logic [N_WAY-1:0][PHYS_REG-1:0]  map_tagOld,
  input  logic [N_WAY-1:0][ARCH_W-1:0]    id_destArch,
  input  logic [N_WAY-1:0]                cdb_valid,
  input  logic [N_WAY-1:0][ROB_PTR-1:0]   cdb_robIdx,
  input  logic                            br_fub_pred_wrong,
  input  logic [ROB_PTR-1:0]              bs_recov_rob_tail,
  output logic [ROB_PTR-1:0]              rob_tail,
  output logic [CNT_W-1:0]                rob_availableSlots,
  output logic [1:0]                      rob_nRetired,
  output logic [N_WAY-1:0][PHYS_REG-1:0]  rob_retireTagOld,
  output logic [N_WAY-1:0][PHYS_REG-1:0]  rob_retireTag,
  output logic [N_WAY-1:0][ARCH_W-1:0]    rob_retireArch
`ifdef ROB_DEBUG_EN
  ,
  output logic [ROB_PTR-1:0]              rob_head,
  output logic [CNT_W-1:0]                rob_count,
  output logic [ROB_SIZE-1:0]             rob_completeVec
`endif
);

  ROB_ENTRY             rob_q [ROB_SIZE];
  logic [ROB_PTR-1:0]   head_q, head_d;
  logic [ROB_PTR-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ROB_PTR-1:0]   head_p1;
  logic [1:0]           disp_n;

  assign head_p1 = head_q + ROB_PTR'(1);

  rob_retire_sel u_retire_sel (
    .head_entry_i (rob_q[head_q]),
    .next_entry_i (rob_q[head_p1]),
    .count_i      (count_q),
    .n_retired_o  (rob_nRetired),
    .tag_o        (rob_retireTag),
    .tag_old_o    (rob_retireTagOld),
    .arch_o       (rob_retireArch)
  );

  // Dispatch handshake: there is no ready back to dispatch. The producer may
  // present haz_nDispatched entries only when that number is no larger than
  // rob_availableSlots + rob_nRetired of the same cycle; the entries are
  // accepted unconditionally at the next posedge unless a mispredict is
  // signalled that cycle, in which case dispatch is discarded.
  always_comb begin
    disp_n  = br_fub_pred_wrong ? 2'd0 : haz_nDispatched;
    head_d  = head_q + ROB_PTR'(rob_nRetired);
    tail_d  = tail_q + ROB_PTR'(disp_n);
    count_d = count_q + CNT_W'(disp_n) - CNT_W'(rob_nRetired);
    // A snapshot equal to the current tail squashes nothing; that case must
    // keep the plain count because the modular distance would read 0 when full.
    if (br_fub_pred_wrong && bs_recov_rob_tail != tail_q) begin
      tail_d  = bs_recov_rob_tail;
      count_d = CNT_W'(ROB_PTR'(bs_recov_rob_tail - head_d));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_SIZE; i++) rob_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < N_WAY; i++) begin
        if (cdb_valid[i]) rob_q[cdb_robIdx[i]].complete <= 1'b1;
      end
      // Written after the CDB update so a stale broadcast aimed at a freshly
      // allocated index loses to the dispatch clear.
      for (int i = 0; i < N_WAY; i++) begin
        if (2'(i) < disp_n) begin
          rob_q[tail_q + ROB_PTR'(i)] <= '{tag:      fl_freeRegs[i],
                                           tagOld:   map_tagOld[i],
                                           destArch: id_destArch[i],
                                           complete: 1'b0};
        end
      end
    end
  end

  assign rob_tail           = tail_q;
  assign rob_availableSlots = CNT_W'(ROB_SIZE) - count_q;

  dispatch_legal: assert property (@(posedge clk) disable iff (!reset_n)
    !br_fub_pred_wrong |-> (haz_nDispatched <= 2'd2 &&
      (CNT_W+1)'(haz_nDispatched) <=
      (CNT_W+1)'(rob_availableSlots) + (CNT_W+1)'(rob_nRetired)));

`ifdef ROB_DEBUG_EN
  assign rob_head  = head_q;
  assign rob_count = count_q;
  always_comb begin
    rob_completeVec = '0;
    for (int i = 0; i < ROB_SIZE; i++) rob_completeVec[i] = rob_q[i].complete;
  end
  always_ff @(posedge clk) begin
    if (reset_n && rob_nRetired != 2'd0)
      $display("rob retire n=%0d tag0=%0d old0=%0d tag1=%0d old1=%0d",
               rob_nRetired, rob_retireTag[0], rob_retireTagOld[0],
               rob_retireTag[1], rob_retireTagOld[1]);
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//   Bench for reorder_buffer. A queue-of-records reference model tracks the
//   in-flight instructions in program order; retirements it predicts go into
//   exp_q and a monitor compares them against the DUT retire slots.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;
  import sys_defs::*;

  logic                            clk = 1'b0;
  logic                            reset_n;
  logic [1:0]                      haz_nDispatched;
  logic [N_WAY-1:0][PHYS_REG-1:0]  fl_freeRegs, map_tagOld;
  logic [N_WAY-1:0][ARCH_W-1:0]    id_destArch;
  logic [N_WAY-1:0]                cdb_valid;
  logic [N_WAY-1:0][ROB_PTR-1:0]   cdb_robIdx;
  logic                            br_fub_pred_wrong;
  logic [ROB_PTR-1:0]              bs_recov_rob_tail;
  logic [ROB_PTR-1:0]              rob_tail;
  logic [CNT_W-1:0]                rob_availableSlots;
  logic [1:0]                      rob_nRetired;
  logic [N_WAY-1:0][PHYS_REG-1:0]  rob_retireTagOld, rob_retireTag;
  logic [N_WAY-1:0][ARCH_W-1:0]    rob_retireArch;

  reorder_buffer dut (
    .clk(clk), .reset_n(reset_n), .haz_nDispatched(haz_nDispatched),
    .fl_freeRegs(fl_freeRegs), .map_tagOld(map_tagOld), .id_destArch(id_destArch),
    .cdb_valid(cdb_valid), .cdb_robIdx(cdb_robIdx),
    .br_fub_pred_wrong(br_fub_pred_wrong), .bs_recov_rob_tail(bs_recov_rob_tail),
    .rob_tail(rob_tail), .rob_availableSlots(rob_availableSlots),
    .rob_nRetired(rob_nRetired), .rob_retireTagOld(rob_retireTagOld),
    .rob_retireTag(rob_retireTag), .rob_retireArch(rob_retireArch)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int W = 2 * PHYS_REG + ARCH_W;   // {tagOld, tag, arch}
  typedef struct {
    int                  idx;
    logic [PHYS_REG-1:0] tag;
    logic [PHYS_REG-1:0] old;
    logic [ARCH_W-1:0]   arch;
    bit                  done;
  } ment_t;

  ment_t          m_q[$];       // in-flight instructions, oldest first
  int             m_head;
  int             m_nret;
  logic [W-1:0]   exp_q[$];
  int             exp_tail, exp_avail, exp_nret;
  bit             mon_en;
  int             n_checks, n_fail;

  logic [PHYS_REG-1:0] d_tag[2], d_old[2];
  logic [ARCH_W-1:0]   d_arch[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cap_nd(input int want);
    int room;
    room = ROB_SIZE - m_q.size() + m_nret;
    return (want < room) ? want : room;
  endfunction

  function automatic int pick_idx();
    if (m_q.size() == 0 || $urandom_range(0, 9) == 0) return $urandom_range(0, ROB_SIZE - 1);
    return m_q[$urandom_range(0, m_q.size() - 1)].idx;
  endfunction

  task automatic rnd_payload();
    for (int i = 0; i < 2; i++) begin
      d_tag[i]  = PHYS_REG'($urandom);
      d_old[i]  = PHYS_REG'($urandom);
      d_arch[i] = ARCH_W'($urandom);
    end
  endtask

  // Start of a cycle: decide what the model retires from the current state.
  task automatic cycle_begin();
    @(negedge clk);
    m_nret = 0;
    if (m_q.size() >= 1 && m_q[0].done) begin
      m_nret = 1;
      if (m_q.size() >= 2 && m_q[1].done) m_nret = 2;
    end
    for (int i = 0; i < m_nret; i++) exp_q.push_back({m_q[i].old, m_q[i].tag, m_q[i].arch});
    exp_nret  = m_nret;
    exp_avail = ROB_SIZE - m_q.size();
    exp_tail  = (m_head + m_q.size()) % ROB_SIZE;
  endtask

  // Drive one cycle of stimulus and advance the model past the next posedge.
  task automatic cycle_drive(input int nd, input bit c0, input bit c1, input int i0,
                             input int i1, input bit mp, input int recov);
    int tail_old, keep;
    haz_nDispatched   = 2'(nd);
    for (int i = 0; i < 2; i++) begin
      fl_freeRegs[i] = d_tag[i];
      map_tagOld[i]  = d_old[i];
      id_destArch[i] = d_arch[i];
    end
    cdb_valid         = {c1, c0};
    cdb_robIdx[0]     = ROB_PTR'(i0);
    cdb_robIdx[1]     = ROB_PTR'(i1);
    br_fub_pred_wrong = mp;
    bs_recov_rob_tail = ROB_PTR'(recov);

    tail_old = (m_head + m_q.size()) % ROB_SIZE;
    if (mp && recov != tail_old) begin
      keep = (recov - m_head + ROB_SIZE) % ROB_SIZE;
      while (m_q.size() > keep) void'(m_q.pop_back());
    end
    for (int r = 0; r < m_nret; r++) void'(m_q.pop_front());
    m_head = (m_head + m_nret) % ROB_SIZE;
    for (int j = 0; j < m_q.size(); j++) begin
      if ((c0 && m_q[j].idx == i0) || (c1 && m_q[j].idx == i1)) m_q[j].done = 1'b1;
    end
    if (!mp) begin
      for (int d = 0; d < nd; d++)
        m_q.push_back('{idx: (tail_old + d) % ROB_SIZE, tag: d_tag[d], old: d_old[d],
                        arch: d_arch[d], done: 1'b0});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cycle_begin();
      cycle_drive(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // Steady-state pattern: complete the two entries behind those retiring now.
  task automatic pipe_cycle(input bit mp);
    int sz;
    bit c0, c1;
    int i0, i1;
    cycle_begin();
    rnd_payload();
    sz = m_q.size();
    c0 = (m_nret < sz);
    c1 = (m_nret + 1 < sz);
    i0 = c0 ? m_q[m_nret].idx : 0;
    i1 = c1 ? m_q[m_nret + 1].idx : 0;
    cycle_drive(cap_nd(2), c0, c1, i0, i1, mp, (m_head + sz) % ROB_SIZE);
  endtask

  task automatic rand_cycle();
    int nd, i0, i1, k;
    bit c0, c1, mp;
    cycle_begin();
    rnd_payload();
    mp = ($urandom_range(0, 15) == 0);
    nd = mp ? $urandom_range(0, 2) : cap_nd($urandom_range(0, 2));
    c0 = ($urandom_range(0, 9) < 6);
    c1 = ($urandom_range(0, 9) < 6);
    i0 = pick_idx();
    i1 = ($urandom_range(0, 4) == 0) ? i0 : pick_idx();
    k  = $urandom_range(m_nret, m_q.size());
    cycle_drive(nd, c0, c1, i0, i1, mp, (m_head + k) % ROB_SIZE);
  endtask

  task automatic drive_idle_inputs();
    haz_nDispatched = '0; fl_freeRegs = '0; map_tagOld = '0; id_destArch = '0;
    cdb_valid = '0; cdb_robIdx = '0; br_fub_pred_wrong = 1'b0; bs_recov_rob_tail = '0;
  endtask

  task automatic check_reset();
    chk("rst_tail",    32'(rob_tail), 0);
    chk("rst_avail",   32'(rob_availableSlots), ROB_SIZE);
    chk("rst_nret",    32'(rob_nRetired), 0);
    chk("rst_tagold",  32'(rob_retireTagOld), 0);
    chk("rst_tag",     32'(rob_retireTag), 0);
    chk("rst_arch",    32'(rob_retireArch), 0);
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_head = 0; m_nret = 0;
    exp_tail = 0; exp_avail = ROB_SIZE; exp_nret = 0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] got, e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        chk("tail",      32'(rob_tail), 32'(exp_tail));
        chk("avail",     32'(rob_availableSlots), 32'(exp_avail));
        chk("n_retired", 32'(rob_nRetired), 32'(exp_nret));
        for (int s = 0; s < 2; s++) begin
          got = {rob_retireTagOld[s], rob_retireTag[s], rob_retireArch[s]};
          if (s < int'(rob_nRetired)) begin
            if (exp_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL retire_slot%0d: actual %0h required none", s, got);
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("retire_slot%0d", s), 32'(got), 32'(e));
            end
          end else begin
            chk($sformatf("retire_zero%0d", s), 32'(got), 0);
          end
        end
        chk("retire_backlog", 32'(exp_q.size()), 0);
        exp_q.delete();
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int h;
    n_checks = 0; n_fail = 0; mon_en = 1'b0;
    reset_n = 1'b0;
    drive_idle_inputs();
    model_reset();
    d_tag = '{default: '0}; d_old = '{default: '0}; d_arch = '{default: '0};
    repeat (3) @(negedge clk);
    #1 check_reset();
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // two dispatched, both completed, both retire together in order
    cycle_begin();
    d_tag[0] = 6'd33; d_tag[1] = 6'd34; d_old[0] = 6'd1; d_old[1] = 6'd2;
    d_arch[0] = 5'd3; d_arch[1] = 5'd4;
    cycle_drive(2, 0, 0, 0, 0, 0, 0);
    cycle_begin();
    cycle_drive(0, 1, 1, m_q[0].idx, m_q[1].idx, 0, 0);
    idle(2);

    // younger completes first: nothing retires until the older completes
    cycle_begin(); rnd_payload(); cycle_drive(2, 0, 0, 0, 0, 0, 0);
    cycle_begin(); cycle_drive(0, 0, 1, 0, m_q[1].idx, 0, 0);
    cycle_begin(); cycle_drive(0, 1, 0, m_q[0].idx, 0, 0, 0);
    idle(2);

    // mispredict squash, then a stale CDB to a re-dispatched index
    h = m_head;
    repeat (3) begin cycle_begin(); rnd_payload(); cycle_drive(2, 0, 0, 0, 0, 0, 0); end
    cycle_begin(); cycle_drive(2, 1, 0, (h + 4) % ROB_SIZE, 0, 1, (h + 3) % ROB_SIZE);
    cycle_begin(); rnd_payload(); cycle_drive(2, 1, 0, (h + 3) % ROB_SIZE, 0, 0, 0);
    cycle_begin(); cycle_drive(0, 1, 1, h, (h + 1) % ROB_SIZE, 0, 0);
    cycle_begin(); cycle_drive(0, 1, 0, (h + 2) % ROB_SIZE, 0, 0, 0);
    idle(3);
    cycle_begin(); cycle_drive(0, 1, 1, (h + 3) % ROB_SIZE, (h + 4) % ROB_SIZE, 0, 0);
    idle(3);

    // fill to full, then run full with two in and two out per cycle (wraps)
    repeat (16) begin cycle_begin(); rnd_payload(); cycle_drive(2, 0, 0, 0, 0, 0, 0); end
    repeat (24) pipe_cycle(1'b0);
    // mispredict with snapshot equal to tail while full and retiring two
    pipe_cycle(1'b1);
    idle(1);

    repeat (700) rand_cycle();

    // asynchronous reset in the middle of a cycle
    cycle_begin(); drive_idle_inputs(); m_nret = 0;
    rnd_payload(); cycle_drive(cap_nd(2), 0, 0, 0, 0, 0, 0);
    #3;
    mon_en  = 1'b0;
    drive_idle_inputs();
    reset_n = 1'b0;
    #1 check_reset();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    repeat (150) rand_cycle();
    idle(2);
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
